// File: rtl/async_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_pkg
// Description : Shared types and constants for the async_fifo read-side
//               stream adapter: FSM state enum, skid-buffer depth bounds and
//               the default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package async_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int BUF_DEPTH_MIN      = 2;
  localparam int BUF_DEPTH_MAX      = 8;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rd_stream_state_e;

endpackage
`default_nettype wire

// File: rtl/async_fifo_rd_stream_if.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_rd_stream_if
// Description : Bundles the FIFO read port (has_data/rd_en/rd_data) and the
//               downstream valid/ready stream (m_valid/m_ready/m_data).
//               master : the adapter (drives rd_en, m_valid, m_data)
//               slave  : the environment (FIFO + consumer)
// Revision    : 1.0 - initial release
// ============================================================================
interface async_fifo_rd_stream_if
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic                  has_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    input  has_data,
    input  rd_data,
    input  m_ready,
    output rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output has_data,
    output rd_data,
    output m_ready,
    input  rd_en,
    input  m_valid,
    input  m_data
  );

endinterface
`default_nettype wire

// File: rtl/rd_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : rd_skid_buf
// Description : BUF_DEPTH-entry circular buffer. Wrapping read/write
//               pointers plus an occupancy counter; clear has priority over
//               push/pop. Storage is reset so the head reads 0 after reset.
// Ports       : clk, rst_n      - clock, async active-low reset
//               push, push_data - write a word at the tail
//               pop             - remove the head word
//               clear           - empty the buffer
//               occ             - number of stored words (0..BUF_DEPTH)
//               head_data       - word at the head
// Revision    : 1.0 - initial release
// ============================================================================
module rd_skid_buf
  import async_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int BUF_DEPTH  = 2,
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1),
  localparam int PTR_W      = $clog2(BUF_DEPTH)
) (
  input  wire                   clk,
  input  wire                   rst_n,
  input  wire                   push,
  input  wire  [DATA_WIDTH-1:0] push_data,
  input  wire                   pop,
  input  wire                   clear,
  output logic [OCC_W-1:0]      occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push, pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occ       = r_occ;
  assign head_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/async_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : async_fifo_rd_stream
// Description : Read-side adapter for async_fifo. Issues rd_en, absorbs the
//               one-cycle rd_data latency into a skid buffer and presents a
//               full-throughput valid/ready stream. A level flush drains and
//               discards FIFO contents; delivered and dropped words are
//               counted (both wrap).
// Ports       : clk, rst_n  - read-domain clock, async active-low reset
//               bus         - FIFO read port + downstream stream (master)
//               flush       - discard everything while high
//               flushing    - high while in the FLUSH state
//               word_count  - words accepted downstream
//               drop_count  - words discarded
// Revision    : 1.0 - initial release
// ============================================================================
module async_fifo_rd_stream
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  wire                  clk,
  input  wire                  rst_n,
  async_fifo_rd_stream_if.master bus,
  input  wire                  flush,
  output logic                 flushing,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int LVL_W = OCC_W + 1;

  if (BUF_DEPTH < BUF_DEPTH_MIN || BUF_DEPTH > BUF_DEPTH_MAX) begin : g_bad_depth
    $error("async_fifo_rd_stream: BUF_DEPTH out of range");
  end

  rd_stream_state_e      r_state;
  rd_stream_state_e      w_state_nxt;
  logic                  r_inflight;
  logic [OCC_W-1:0]      w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_m_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_clear;
  logic                  w_rd_en;
  logic [LVL_W-1:0]      w_level;
  logic [CNT_WIDTH-1:0]  w_drop_inc;

  rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (bus.rd_data),
    .pop       (w_pop),
    .clear     (w_clear),
    .occ       (w_occ),
    .head_data (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_inflight <= 1'b0;
      word_count <= '0;
      drop_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_rd_en;
      word_count <= word_count + CNT_WIDTH'(w_pop);
      drop_count <= drop_count + w_drop_inc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_m_valid   = 1'b0;
    w_rd_en     = 1'b0;
    w_push      = 1'b0;
    w_clear     = 1'b0;
    w_level     = '0;
    w_drop_inc  = '0;
    case (r_state)
      RUN: begin
        w_m_valid = (w_occ != '0);
        // Words the buffer will hold after this edge; a new read is only
        // issued if its word is guaranteed a free slot when it lands.
        w_level   = LVL_W'(w_occ) + LVL_W'(r_inflight)
                  - LVL_W'(w_m_valid & bus.m_ready);
        w_rd_en   = bus.has_data && (w_level < LVL_W'(BUF_DEPTH));
        if (flush) begin
          // Clear overrides the arriving word, so that word is dropped
          // together with whatever survives this cycle's pop.
          w_state_nxt = FLUSH;
          w_clear     = 1'b1;
          w_drop_inc  = CNT_WIDTH'(w_level);
        end else begin
          w_push = r_inflight;
        end
      end
      FLUSH: begin
        w_rd_en    = bus.has_data;
        w_drop_inc = CNT_WIDTH'(r_inflight);
        if (!flush && !r_inflight) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
    // The FIFO must never see a read strobe while this block is in reset.
    w_rd_en = w_rd_en & rst_n;
  end

  assign w_pop       = w_m_valid & bus.m_ready;
  assign bus.rd_en   = w_rd_en;
  assign bus.m_valid = w_m_valid;
  assign bus.m_data  = w_head;
  assign flushing    = (r_state == FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_async_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_fifo_rd_stream
// Description : Self-checking bench for async_fifo_rd_stream. A queue-based
//               FIFO model feeds the adapter, a consumer monitor collects
//               delivered words, and results are compared against expected
//               sequences and counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_fifo_rd_stream;

  localparam int DW = 8;
  localparam int BD = 2;
  localparam int CW = 16;

  typedef logic [DW-1:0] dq_t[$];

  typedef struct {
    int n_words;
    int ready_pct;
    int load_pct;
    bit do_flush;
    int exp_wc;
    int exp_dc;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          flushing;
  logic [CW-1:0] word_count;
  logic [CW-1:0] drop_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int run_len = 0;
  int max_run = 0;
  int ready_mode = 0;
  bit tog = 1'b0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] got[$];
  int            got_cyc[$];
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;

  async_fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

  async_fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (BD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .flushing   (flushing),
    .word_count (word_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  // FIFO model: rd_data appears the cycle after rd_en; has_data reflects
  // the queue after each edge.
  always @(posedge clk) begin
    cyc++;
    if (bus.rd_en) begin
      rd_cnt++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      checks++;
      if (!bus.has_data || fifo_q.size() == 0) begin
        errors++;
        $display("FAIL rd_en_empty: rd_en=1 with has_data=%0b queued=%0d, required no read",
                 bus.has_data, fifo_q.size());
      end else begin
        bus.rd_data <= fifo_q.pop_front();
      end
    end else begin
      run_len = 0;
    end
    bus.has_data <= (fifo_q.size() != 0);
  end

  // Consumer ready: percentage, or alternate every cycle when negative.
  always @(posedge clk) begin
    #1;
    if (ready_mode < 0) begin
      tog = ~tog;
      bus.m_ready = tog;
    end else begin
      bus.m_ready = ($urandom_range(99) < ready_mode);
    end
  end

  // Consumer monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(bus.m_valid && bus.m_data == prev_data)) begin
          errors++;
          $display("FAIL stall_hold: m_valid=%0b m_data=%0h, required 1 and %0h",
                   bus.m_valid, bus.m_data, prev_data);
        end
      end
      if (flushing) begin
        checks++;
        if (bus.m_valid) begin
          errors++;
          $display("FAIL flush_valid: m_valid=1 while flushing, required 0");
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        got.push_back(bus.m_data);
        got_cyc.push_back(cyc);
      end
      prev_stall = bus.m_valid && !bus.m_ready && !flush;
      prev_data  = bus.m_data;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic dq_t ramp(input int first, input int n);
    dq_t q;
    for (int i = 0; i < n; i++) q.push_back(DW'(first + i));
    return q;
  endfunction

  task automatic load_q(input dq_t q);
    foreach (q[i]) fifo_q.push_back(q[i]);
  endtask

  task automatic check_seq(input string name, input dq_t exp);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, got[i], exp[i]);
  endtask

  task automatic wait_got(input int n, input int budget, input string name);
    int k = 0;
    while (got.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check({name, "_wait"}, got.size() >= n, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    fifo_q.delete();
    tick(3);
    got.delete();
    got_cyc.delete();
    rd_cnt  = 0;
    max_run = 0;
    rst_n   = 1'b1;
    tick(1);
  endtask

  vec_t vecs[5];

  initial begin
    dq_t exp;
    dq_t pushed;

    // Reset state, with has_data possibly unknown/high on the FIFO side.
    rst_n = 1'b0;
    tick(2);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_flushing", flushing, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_word_count", word_count, 0);
    check("rst_drop_count", drop_count, 0);

    // Full-throughput stream.
    do_reset();
    ready_mode = 100;
    load_q(ramp(0, 16));
    wait_got(16, 100, "stream");
    tick(4);
    check("stream_rd_run", max_run, 16);
    check("stream_rd_cnt", rd_cnt, 16);
    check_seq("stream_data", ramp(0, 16));
    if (got_cyc.size() == 16) check("stream_gapless", got_cyc[15] - got_cyc[0], 15);
    check("stream_wc", word_count, 16);
    check("stream_dc", drop_count, 0);

    // Back-pressure: only BD reads outstanding, head held.
    do_reset();
    ready_mode = 0;
    tick(1);
    load_q(ramp(0, 16));
    tick(10);
    check("bp_rd_cnt", rd_cnt, BD);
    check("bp_m_valid", bus.m_valid, 1);
    check("bp_m_data", bus.m_data, 0);
    ready_mode = 100;
    wait_got(16, 100, "bp");
    tick(2);
    check_seq("bp_data", ramp(0, 16));
    check("bp_wc", word_count, 16);

    // Alternating ready.
    do_reset();
    ready_mode = -1;
    load_q(ramp(0, 16));
    wait_got(16, 200, "toggle");
    tick(4);
    check_seq("toggle_data", ramp(0, 16));
    check("toggle_wc", word_count, 16);
    check("toggle_rd_cnt", rd_cnt, 16);

    // Flush with words 4..15 pending, then resume.
    do_reset();
    ready_mode = 100;
    load_q(ramp(0, 4));
    wait_got(4, 50, "fl_pre");
    tick(3);
    ready_mode = 0;
    tick(2);
    load_q(ramp(4, 12));
    tick(6);
    flush = 1'b1;
    tick(20);
    check("fl_flushing", flushing, 1);
    flush = 1'b0;
    tick(2);
    check("fl_exit", flushing, 0);
    check("fl_has_data", bus.has_data, 0);
    check("fl_dc", drop_count, 12);
    check("fl_wc", word_count, 4);
    check("fl_rd_cnt", rd_cnt, 16);
    ready_mode = 100;
    load_q(ramp(16, 4));
    wait_got(8, 50, "fl_post");
    tick(2);
    exp = ramp(0, 4);
    for (int i = 16; i < 20; i++) exp.push_back(DW'(i));
    check_seq("fl_data", exp);
    check("fl_wc_post", word_count, 8);
    check("fl_dc_post", drop_count, 12);

    // Single word, has_data drops right after the read.
    do_reset();
    ready_mode = 100;
    fifo_q.push_back(8'hA5);
    tick(12);
    check("one_rd_cnt", rd_cnt, 1);
    check_seq("one_data", '{8'hA5});
    check("one_wc", word_count, 1);
    check("one_m_valid", bus.m_valid, 0);

    // Reset mid-stream with a full buffer.
    do_reset();
    ready_mode = 100;
    load_q(ramp(0, 4));
    wait_got(4, 50, "mr_pre");
    ready_mode = 0;
    tick(2);
    load_q(ramp(4, 8));
    tick(8);
    check("mr_full_valid", bus.m_valid, 1);
    check("mr_wc_before", word_count, 4);
    check("mr_rd_cnt", rd_cnt, 6);
    #1;
    rst_n = 1'b0;
    fifo_q.delete();
    #1;
    check("mr_m_valid", bus.m_valid, 0);
    check("mr_rd_en", bus.rd_en, 0);
    check("mr_wc", word_count, 0);
    check("mr_dc", drop_count, 0);
    @(posedge clk);
    #1;
    tick(2);
    got.delete();
    got_cyc.delete();
    rd_cnt = 0;
    rst_n = 1'b1;
    ready_mode = 100;
    tick(1);
    load_q(ramp(100, 8));
    wait_got(8, 60, "mr_post");
    tick(2);
    check_seq("mr_post_data", ramp(100, 8));
    check("mr_post_wc", word_count, 8);

    // Table of randomized streaming scenarios.
    vecs[0] = '{24,  50,  60, 1'b0, 24, 0};
    vecs[1] = '{24,  90,  30, 1'b0, 24, 0};
    vecs[2] = '{24,  20,  90, 1'b0, 24, 0};
    vecs[3] = '{16, 100, 100, 1'b0, 16, 0};
    vecs[4] = '{ 6,   0, 100, 1'b1,  0, 6};
    for (int v = 0; v < 5; v++) begin
      do_reset();
      ready_mode = vecs[v].ready_pct;
      pushed.delete();
      while (pushed.size() < vecs[v].n_words) begin
        if ($urandom_range(99) < vecs[v].load_pct) begin
          pushed.push_back(DW'($urandom));
          fifo_q.push_back(pushed[pushed.size() - 1]);
        end
        tick(1);
      end
      if (vecs[v].do_flush) begin
        tick(10);
        flush = 1'b1;
        tick(12);
        flush = 1'b0;
        tick(3);
      end else begin
        wait_got(vecs[v].n_words, 2000, "vec");
        tick(4);
      end
      exp.delete();
      for (int i = 0; i < vecs[v].exp_wc; i++) exp.push_back(pushed[i]);
      check_seq("vec_data", exp);
      check("vec_wc", word_count, vecs[v].exp_wc);
      check("vec_dc", drop_count, vecs[v].exp_dc);
      check("vec_reads", rd_cnt, vecs[v].exp_wc + vecs[v].exp_dc);
    end

    // Random flush pulses: delivered words are an in-order subsequence and
    // every word read is either delivered or dropped.
    begin
      int  j;
      int  k;
      bit  ok;
      do_reset();
      ready_mode = 50;
      pushed.delete();
      while (pushed.size() < 60) begin
        if ($urandom_range(99) < 70) begin
          pushed.push_back(DW'(pushed.size()));
          fifo_q.push_back(pushed[pushed.size() - 1]);
        end
        flush = ($urandom_range(99) < 8);
        tick(1);
      end
      flush = 1'b0;
      ready_mode = 100;
      k = 0;
      while ((fifo_q.size() != 0 || bus.has_data || bus.m_valid || flushing) && k < 300) begin
        tick(1);
        k++;
      end
      tick(4);
      check("rf_settle", k < 300, 1);
      j  = 0;
      ok = 1'b1;
      foreach (got[i]) begin
        while (j < pushed.size() && pushed[j] != got[i]) j++;
        if (j == pushed.size()) ok = 1'b0;
        else j++;
      end
      check("rf_order", ok, 1);
      check("rf_wc", word_count, got.size());
      check("rf_dc", drop_count, rd_cnt - got.size());
      check("rf_reads", rd_cnt, pushed.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/async_fifo_rd_stream.md
# async_fifo_rd_stream

Read-side adapter for `async_fifo`. It sits in the read clock domain, drives the FIFO's `rd_en`, and absorbs the fixed one-cycle `rd_data` latency. It presents words downstream as a valid/ready stream at full throughput, with a small skid buffer, a flush mode that drains and discards FIFO contents, and delivered/dropped word counters.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `BUF_DEPTH`, 2, skid-buffer entries; legal range 2..8.
- `CNT_WIDTH`, 16, width of `word_count` and `drop_count`.

Ports (clock and reset first):
- `clk`  in  1  read-domain clock; same clock as the FIFO `rd_clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `has_data`  in  1  FIFO holds at least one readable word.
- `rd_en`  out  1  FIFO read strobe.
- `rd_data`  in  DATA_WIDTH  FIFO output; valid the cycle after `rd_en`.
- `m_valid`  out  1  `m_data` holds a word.
- `m_ready`  in  1  consumer accepts the word this cycle.
- `m_data`  out  DATA_WIDTH  head of the skid buffer.
- `flush`  in  1  level; discard everything while high.
- `flushing`  out  1  block is in the FLUSH state.
- `word_count`  out  CNT_WIDTH  words accepted downstream; wraps.
- `drop_count`  out  CNT_WIDTH  words discarded; wraps.

## Operation
- Internal state: `occ` (0..BUF_DEPTH) is buffer occupancy; `inflight` is a registered copy of `rd_en` (1 means a word arrives on `rd_data` this cycle); `pop` = `m_valid & m_ready`.
- States:
  - RUN → FLUSH when `flush`=1.
  - FLUSH → RUN when `flush`=0 and `inflight`=0.
- RUN behaviour:
  - `rd_en` = `has_data & (occ + inflight - pop < BUF_DEPTH)`.
  - An `inflight` word is written at the tail. A pop removes the head. Push and pop in the same cycle leave `occ` unchanged.
  - `m_valid` = (`occ` != 0). The buffer is strict FIFO order.
- FLUSH behaviour:
  - On entry, the buffer is cleared (`occ`←0). Every cleared word is added to `drop_count`.
  - `rd_en` = `has_data`.
  - Each `inflight` word, including a read issued in the last RUN cycle, is discarded and increments `drop_count`.
  - `m_valid`=0.
- Counters: `word_count` += 1 per pop. `drop_count` += words discarded that cycle, which can be more than 1 on FLUSH entry. Both wrap modulo 2^CNT_WIDTH.
- `rd_en` is never asserted unless `has_data`=1. The block never reads an empty FIFO.

## Timing
- Reset values (async on `rst_n`=0):
  - state=RUN, `occ`=0, `inflight`=0, `word_count`=0, `drop_count`=0.
  - `rd_en`=0, `m_valid`=0, `flushing`=0, `m_data`=0.
  - `rd_en` is forced 0 while `rst_n`=0.
- Latency: `rd_en` in cycle t → `rd_data` sampled in t+1 → `m_valid` in t+2.
- Throughput: one word per cycle with `m_ready` held high and `has_data` high.
- Back-pressure: with `m_ready`=0, at most BUF_DEPTH reads are outstanding. After that `rd_en` stays 0 until a pop.
- `has_data` falls while a read is in flight: the in-flight word is still captured, and no new read is issued.
- `flush` asserted on the same cycle as a pop: the pop completes and is counted in `word_count`. The remaining entries are dropped.
- `m_data` is stable while `m_valid`=1 and `m_ready`=0.
- Reset mid-stream: buffered and in-flight words are lost and not counted. The FIFO-side reset is owned by the system.

## Structure
- `async_fifo_pkg` holds:
  - the state enum `rd_stream_state_e` (RUN, FLUSH);
  - the `BUF_DEPTH` bounds constants;
  - the shared default `DATA_WIDTH`.
- Sub-module `rd_skid_buf`: a BUF_DEPTH-entry circular buffer with push, pop and clear inputs, and `occ` and head-data outputs. It carries wrapping pointers and an occupancy counter.
- The top level holds the FSM, the `rd_en` logic, the `inflight` register and the counters.

## Test plan
1. Stream: FIFO preloaded with 0..15, `m_ready`=1 → `rd_en` high for 16 consecutive cycles, `m_data` is 0..15 in order with no gaps, `word_count`=16, `drop_count`=0.
2. Back-pressure: preload 0..15, `m_ready`=0 → exactly 2 `rd_en` pulses and `m_valid`=1 holding `m_data`=0. Release `m_ready` → 0..15 are delivered in order.
3. Toggling `m_ready` (1,0,1,0…) with 16 words → no loss and no duplicate, `m_data` stays stable while stalled, `word_count`=16.
4. Flush: deliver 0..3, then pulse `flush` for 20 cycles with words 4..15 in the FIFO → `m_valid`=0 throughout, `drop_count`=12, `has_data`=0 at exit. Then load 16..19 → 16..19 are delivered.
5. Underflow edge: a single word 0xA5 with `has_data` dropping after the read → exactly one `rd_en`, one delivery of 0xA5, and no spurious `m_valid`.
6. Reset mid-stream: assert `rst_n`=0 while `occ`=2 → `m_valid`, `rd_en`, `word_count` and `drop_count` go to 0 immediately. After release, normal streaming resumes.
